// File: rtl/inst_fetch_pkg.sv
// Purpose : shared constants and types for the instruction-fetch stage.
// Contents: bus widths, chip-enable levels, zero word, fetch FSM states and
//           the default sequential PC increment.
package inst_fetch_pkg;

  // Bus widths reused across the pipeline.
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  // Common constant values.
  localparam logic [InstBus-1:0] ZeroWord    = 32'h0000_0000;
  localparam logic               ChipEnable  = 1'b1;
  localparam logic               ChipDisable = 1'b0;

  // Default byte increment between sequential fetches.
  localparam int unsigned PC_STEP_DFLT = 4;

  // Fetch controller states.
  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Purpose : instruction-fetch initiator; owns the PC, drives the combinational
//           instruction ROM and registers {pc, inst} into the IF/ID slot.
// Ports   : clk/rst (async, active-high); rom_ce_o/rom_addr_o/rom_inst_i ROM
//           interface; branch_flag_i/branch_target_i redirect from ID;
//           flush_i/flush_pc_i exception flush; id_ready_i/id_valid_o/
//           id_pc_o/id_inst_o IF/ID valid-ready slot.
// Latency : ROM word appears on id_* one clock after its address is presented.
// Backpressure: while id_valid_o=1 and id_ready_i=0, pc and id_* hold; a
//           branch seen during the stall is remembered and applied after the
//           delay-slot instruction is delivered.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_W   = InstAddrBus,
  parameter int unsigned           INST_W   = InstBus,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter int unsigned           PC_STEP  = PC_STEP_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_rom_ce;
  logic              r_id_valid;
  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic              r_redir_pend;
  logic [ADDR_W-1:0] r_redir_pc;
  logic              w_fire;
  logic [ADDR_W-1:0] w_next_pc;

  // Next-state, fire condition and next-PC selection.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_next_pc   = r_pc + ADDR_W'(PC_STEP);
    case (r_state)
      FETCH_IDLE: w_state_nxt = FETCH_RUN;
      FETCH_RUN:  w_fire      = !r_id_valid || id_ready_i;
    endcase
    // A branch this cycle beats an older remembered redirect: newest wins.
    if (branch_flag_i) begin
      w_next_pc = branch_target_i;
    end else if (r_redir_pend) begin
      w_next_pc = r_redir_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH_IDLE;
      r_pc         <= RESET_PC;
      r_rom_ce     <= ChipDisable;
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_id_inst    <= INST_W'(ZeroWord);
      r_redir_pend <= 1'b0;
      r_redir_pc   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rom_ce <= (w_state_nxt == FETCH_RUN) ? ChipEnable : ChipDisable;
      if (flush_i) begin
        // Flush discards the slot and any remembered redirect; no fetch.
        r_pc         <= flush_pc_i;
        r_id_valid   <= 1'b0;
        r_redir_pend <= 1'b0;
      end else if (w_fire) begin
        // The instruction at the current pc is delivered even when a branch
        // is signalled now: it is the delay slot.
        r_id_valid   <= 1'b1;
        r_id_pc      <= r_pc;
        r_id_inst    <= rom_inst_i;
        r_pc         <= w_next_pc;
        r_redir_pend <= 1'b0;
      end else begin
        // Delay slot not yet delivered: park the target until it fires.
        if (branch_flag_i) begin
          r_redir_pend <= 1'b1;
          r_redir_pc   <= branch_target_i;
        end
        // Consume without refill; only reachable outside RUN.
        if (r_id_valid && id_ready_i) begin
          r_id_valid <= 1'b0;
        end
      end
    end
  end

  assign rom_ce_o   = r_rom_ce;
  assign rom_addr_o = r_pc;
  assign id_valid_o = r_id_valid;
  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;

endmodule
